// File: rtl/icache_direct_if.sv
// Request/response bus shared by the issuer-facing and memory-facing sides of the cache.
// The master drives requests and receives responses; the slave accepts requests and answers.
interface icache_direct_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_addr;
  logic [31:0] resp_inst;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_addr, resp_inst
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_addr, resp_inst
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache with blocking miss handling
// and deferred flush (fence.i) for requests already in flight.
module icache_direct #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  icache_direct_if.slave         fetch,
  icache_direct_if.master        mem,
  input  logic                   flush,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              req_addr_q;
  logic [DEPTH-1:0]         valid_q;
  logic                     flush_pending_q;
  logic [TAG_W-1:0]         tag_mem  [DEPTH];
  logic [31:0]              data_mem [DEPTH];
  logic [TAG_W-1:0]         rd_tag_q;
  logic [31:0]              rd_data_q;

  logic [INDEX_WIDTH-1:0]   acc_idx, req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic                     accept, hit, fill_match, fill_write;
  logic                     unused_resp_lsb;

  assign acc_idx    = fetch.req_addr[INDEX_WIDTH+1:2];
  assign req_idx    = req_addr_q[INDEX_WIDTH+1:2];
  assign req_tag    = req_addr_q[31:INDEX_WIDTH+2];

  assign fetch.req_ready  = (state_q == IDLE) && !flush && !flush_pending_q;
  assign fetch.resp_valid = (state_q == RESP);
  assign mem.req_valid    = (state_q == MISS_REQ);

  assign accept     = fetch.req_valid && fetch.req_ready;
  assign hit        = valid_q[req_idx] && (rd_tag_q == req_tag);
  // Byte offset of the memory response is irrelevant to matching.
  assign fill_match = mem.resp_valid && (mem.resp_addr[31:2] == req_addr_q[31:2]);
  assign fill_write = (state_q == MISS_WAIT) && fill_match;
  assign unused_resp_lsb = ^mem.resp_addr[1:0];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept)        state_d = LOOKUP;
      LOOKUP:    state_d = hit ? RESP : MISS_REQ;
      MISS_REQ:  if (mem.req_ready) state_d = MISS_WAIT;
      MISS_WAIT: if (fill_match)    state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      req_addr_q      <= '0;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      hit_count       <= '0;
      miss_count      <= '0;
      fetch.resp_addr <= '0;
      fetch.resp_inst <= '0;
      mem.req_addr    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) req_addr_q <= fetch.req_addr;

      if (state_q == LOOKUP) begin
        if (hit) begin
          hit_count       <= hit_count + 32'd1;
          fetch.resp_addr <= req_addr_q;
          fetch.resp_inst <= rd_data_q;
        end else begin
          miss_count   <= miss_count + 32'd1;
          mem.req_addr <= {req_addr_q[31:2], 2'b00};
        end
      end

      if (fill_write) begin
        valid_q[req_idx] <= 1'b1;
        fetch.resp_addr  <= req_addr_q;
        fetch.resp_inst  <= mem.resp_inst;
      end

      // An in-flight request finishes first; the invalidate lands on the next IDLE cycle.
      if (state_q == IDLE) begin
        if (flush || flush_pending_q) begin
          valid_q         <= '0;
          flush_pending_q <= 1'b0;
        end
      end else if (flush) begin
        flush_pending_q <= 1'b1;
      end
    end
  end

  // NOTE: the tag/data arrays carry no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_tag_q  <= tag_mem[acc_idx];
      rd_data_q <= data_mem[acc_idx];
    end
    if (fill_write) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= mem.resp_inst;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus randomized fetches
// checked against a line-address map model of the cache contents.
module tb_icache_direct;
  localparam int IW    = 6;
  localparam int DEPTH = 1 << IW;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] hit_count, miss_count;

  icache_direct_if fetch_bus ();
  icache_direct_if mem_bus ();

  icache_direct #(.INDEX_WIDTH(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch      (fetch_bus),
    .mem        (mem_bus),
    .flush      (flush),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] n_hit  = '0;
  logic [31:0] n_miss = '0;
  // Model: which word address each line currently holds.
  bit [29:0]   line_addr [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'h10) return 32'h0000_0013;
    return {a[31:2], 2'b00} ^ 32'h5EED_0000 ^ {a[9:2], 24'h0};
  endfunction

  task automatic do_fetch(input logic [31:0] a, input int rdy_wait, input int resp_wait,
                          input bit wrong_first, input bit early_resp, input bit flush_mid);
    logic [31:0] d;
    bit          h, fm;
    int          idx;
    idx = int'((a >> 2) % DEPTH);
    h   = line_addr.exists(idx) && (line_addr[idx] == a[31:2]);
    fm  = flush_mid && !h;
    d   = mem_word(a);

    check("ready_idle", 32'(fetch_bus.req_ready), 32'd1);
    fetch_bus.req_valid = 1'b1;
    fetch_bus.req_addr  = a;
    @(negedge clk);
    fetch_bus.req_valid = 1'b0;
    fetch_bus.req_addr  = $urandom;
    check("lookup_no_resp", 32'(fetch_bus.resp_valid), 32'd0);
    check("lookup_no_memreq", 32'(mem_bus.req_valid), 32'd0);
    @(negedge clk);
    if (h) begin
      n_hit++;
      check("hit_resp_valid", 32'(fetch_bus.resp_valid), 32'd1);
      check("hit_resp_addr", fetch_bus.resp_addr, a);
      check("hit_resp_inst", fetch_bus.resp_inst, d);
      check("hit_no_memreq", 32'(mem_bus.req_valid), 32'd0);
      check("hit_count", hit_count, n_hit);
    end else begin
      n_miss++;
      check("miss_count", miss_count, n_miss);
      check("miss_memreq_valid", 32'(mem_bus.req_valid), 32'd1);
      check("miss_memreq_addr", mem_bus.req_addr, {a[31:2], 2'b00});
      check("miss_no_resp", 32'(fetch_bus.resp_valid), 32'd0);
      repeat (rdy_wait) begin
        @(negedge clk);
        check("stall_memreq_valid", 32'(mem_bus.req_valid), 32'd1);
        check("stall_memreq_addr", mem_bus.req_addr, {a[31:2], 2'b00});
      end
      mem_bus.req_ready = 1'b1;
      if (early_resp) begin
        mem_bus.resp_valid = 1'b1;
        mem_bus.resp_addr  = a;
        mem_bus.resp_inst  = ~d;
      end
      @(negedge clk);
      mem_bus.req_ready  = 1'b0;
      mem_bus.resp_valid = 1'b0;
      check("wait_memreq_low", 32'(mem_bus.req_valid), 32'd0);
      check("wait_no_resp", 32'(fetch_bus.resp_valid), 32'd0);
      repeat (resp_wait) begin
        @(negedge clk);
        check("wait_no_resp", 32'(fetch_bus.resp_valid), 32'd0);
      end
      if (fm) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
      if (wrong_first) begin
        mem_bus.resp_valid = 1'b1;
        mem_bus.resp_addr  = a ^ 32'h4;
        mem_bus.resp_inst  = ~d;
        @(negedge clk);
        mem_bus.resp_valid = 1'b0;
        check("wrong_resp_ignored", 32'(fetch_bus.resp_valid), 32'd0);
      end
      mem_bus.resp_valid = 1'b1;
      mem_bus.resp_addr  = {a[31:2], 2'($urandom)};
      mem_bus.resp_inst  = d;
      @(negedge clk);
      mem_bus.resp_valid = 1'b0;
      mem_bus.resp_inst  = $urandom;
      check("fill_resp_valid", 32'(fetch_bus.resp_valid), 32'd1);
      check("fill_resp_addr", fetch_bus.resp_addr, a);
      check("fill_resp_inst", fetch_bus.resp_inst, d);
      line_addr[idx] = a[31:2];
    end
    @(negedge clk);
    check("resp_one_cycle", 32'(fetch_bus.resp_valid), 32'd0);
    if (fm) begin
      check("pending_flush_ready", 32'(fetch_bus.req_ready), 32'd0);
      line_addr.delete();
      @(negedge clk);
    end
    check("ready_after", 32'(fetch_bus.req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    flush = 1'b0;
    fetch_bus.req_valid = 1'b0;
    fetch_bus.req_addr  = '0;
    mem_bus.req_ready   = 1'b0;
    mem_bus.resp_valid  = 1'b0;
    mem_bus.resp_addr   = '0;
    mem_bus.resp_inst   = '0;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", 32'(fetch_bus.resp_valid), 32'd0);
    check("rst_memreq_valid", 32'(mem_bus.req_valid), 32'd0);
    check("rst_memreq_addr", mem_bus.req_addr, 32'd0);
    check("rst_resp_addr", fetch_bus.resp_addr, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss then hit.
    do_fetch(32'h40, 0, 2, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h40, 0, 0, 1'b0, 1'b0, 1'b0);
    check("t1_hits", hit_count, 32'd1);
    check("t1_misses", miss_count, 32'd1);

    // Conflict eviction on index 0.
    do_fetch(32'h000, 0, 1, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h100, 0, 1, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h000, 0, 1, 1'b0, 1'b0, 1'b0);
    check("t2_misses", miss_count, 32'd4);

    // Flush in IDLE wins over a simultaneous request.
    flush = 1'b1;
    fetch_bus.req_valid = 1'b1;
    fetch_bus.req_addr  = 32'h40;
    #1;
    check("idle_flush_ready", 32'(fetch_bus.req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    fetch_bus.req_valid = 1'b0;
    line_addr.delete();
    check("idle_flush_no_accept", 32'(fetch_bus.resp_valid), 32'd0);
    @(negedge clk);
    check("idle_flush_still_idle", 32'(fetch_bus.resp_valid | mem_bus.req_valid), 32'd0);

    // Refetch misses, with memory backpressure, a same-cycle response and a mismatched response.
    do_fetch(32'h40, 5, 1, 1'b1, 1'b1, 1'b0);

    // Flush while waiting on a fill; the fill still completes, then the line is gone.
    do_fetch(32'h80, 1, 2, 1'b0, 1'b0, 1'b1);
    do_fetch(32'h80, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a fill.
    fetch_bus.req_valid = 1'b1;
    fetch_bus.req_addr  = 32'h300;
    @(negedge clk);
    fetch_bus.req_valid = 1'b0;
    @(negedge clk);
    mem_bus.req_ready = 1'b1;
    @(negedge clk);
    mem_bus.req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_resp_valid", 32'(fetch_bus.resp_valid), 32'd0);
    check("mid_rst_memreq_valid", 32'(mem_bus.req_valid), 32'd0);
    check("mid_rst_memreq_addr", mem_bus.req_addr, 32'd0);
    check("mid_rst_resp_addr", fetch_bus.resp_addr, 32'd0);
    check("mid_rst_resp_inst", fetch_bus.resp_inst, 32'd0);
    check("mid_rst_hits", hit_count, 32'd0);
    check("mid_rst_misses", miss_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    line_addr.delete();
    n_hit  = '0;
    n_miss = '0;
    mem_bus.resp_valid = 1'b1;
    mem_bus.resp_addr  = 32'h300;
    mem_bus.resp_inst  = mem_word(32'h300);
    @(negedge clk);
    mem_bus.resp_valid = 1'b0;
    check("late_resp_ignored", 32'(fetch_bus.resp_valid), 32'd0);
    @(negedge clk);
    check("late_resp_ignored2", 32'(fetch_bus.resp_valid), 32'd0);
    check("post_rst_hits", hit_count, 32'd0);
    check("post_rst_misses", miss_count, 32'd0);
    do_fetch(32'h300, 0, 1, 1'b0, 1'b0, 1'b0);

    // Randomized fetches over a small conflicting address pool.
    for (int i = 0; i < 60; i++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
        | 32'($urandom_range(0, 3));
      do_fetch(a, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    // Hit counter wraps.
    do_fetch(32'h40, 0, 0, 1'b0, 1'b0, 1'b0);
    force dut.hit_count = 32'hFFFF_FFFF;
    #1;
    release dut.hit_count;
    n_hit = 32'hFFFF_FFFF;
    do_fetch(32'h40, 0, 0, 1'b0, 1'b0, 1'b0);
    check("hit_wrap", hit_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
